// File: rtl/axistream_packet_arbiter.sv
// ---------------------------------------------------------------------------
// axistream_packet_arbiter
//
// Round-robin, packet-locked arbiter that merges NUM_SRC wide AXI-Stream
// sources into one registered wide stream feeding a beat unpacker.
//
// Ports
//   clk          : sole clock, rising edge
//   rst_n        : asynchronous active-low reset
//   src_tvalid   : [NUM_SRC]     per-source valid
//   src_tready   : [NUM_SRC]     per-source ready (only the granted bit can be 1)
//   src_tdata    : [NUM_SRC*W]   source k in bits [(k+1)*W-1 : k*W]
//   src_tlast    : [NUM_SRC]     per-source end of packet
//   dest_tvalid  : registered wide word valid
//   dest_tready  : downstream ready
//   dest_tdata   : [W] registered wide word
//   dest_tlast   : registered end of packet
//   dest_tid     : [TID_W] index of the source that produced dest_tdata
//   busy         : high while a packet grant is held
// ---------------------------------------------------------------------------
module axistream_packet_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PACK   = 4,
    parameter int NUM_SRC    = 2,
    localparam int W         = NUM_PACK * DATA_WIDTH,
    localparam int TID_W     = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     src_tvalid,
    output logic [NUM_SRC-1:0]     src_tready,
    input  logic [NUM_SRC*W-1:0]   src_tdata,
    input  logic [NUM_SRC-1:0]     src_tlast,
    output logic                   dest_tvalid,
    input  logic                   dest_tready,
    output logic [W-1:0]           dest_tdata,
    output logic                   dest_tlast,
    output logic [TID_W-1:0]       dest_tid,
    output logic                   busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [TID_W-1:0]  grant_reg, grant_next;
    logic [TID_W-1:0]  last_grant_reg, last_grant_next;

    logic [W-1:0]      data_reg;
    logic              last_reg;
    logic              valid_reg;
    logic [TID_W-1:0]  tid_reg;

    logic [W-1:0]      src_word [NUM_SRC];
    logic              slot_ready;
    logic              accept;
    logic              pick_found;
    logic [TID_W-1:0]  pick_idx;

    // Split the flat source bus into per-source words.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_split
        assign src_word[gi] = src_tdata[gi*W +: W];
    end

    // The output register can take a new word when empty or draining now.
    assign slot_ready = !valid_reg || dest_tready;
    assign accept     = (state_reg == LOCK) && src_tvalid[grant_reg] && slot_ready;

    // Round-robin search: start one past the last packet's owner and wrap,
    // so the source that just finished has the lowest priority.
    always_comb begin
        int               cand;
        logic [TID_W-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand     = (int'(last_grant_reg) + i) % NUM_SRC;
            cand_idx = TID_W'(cand);
            if (!pick_found && src_tvalid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= TID_W'(NUM_SRC - 1);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_idx;
                    state_next = LOCK;
                end
            end
            LOCK: begin
                // Only the tlast beat releases the grant; valid gaps keep it.
                if (accept && src_tlast[grant_reg]) begin
                    state_next      = IDLE;
                    last_grant_next = grant_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        src_tready = '0;
        busy       = (state_reg == LOCK);
        if (state_reg == LOCK) begin
            src_tready[grant_reg] = slot_ready;
        end
    end

    // Registered output stage; an accept in the same cycle as a drain
    // simply reloads, giving one word per cycle with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            last_reg  <= 1'b0;
            valid_reg <= 1'b0;
            tid_reg   <= '0;
        end else if (accept) begin
            data_reg  <= src_word[grant_reg];
            last_reg  <= src_tlast[grant_reg];
            tid_reg   <= grant_reg;
            valid_reg <= 1'b1;
        end else if (valid_reg && dest_tready) begin
            valid_reg <= 1'b0;
        end
    end

    assign dest_tvalid = valid_reg;
    assign dest_tdata  = data_reg;
    assign dest_tlast  = last_reg;
    assign dest_tid    = tid_reg;

endmodule

// File: tb/tb_axistream_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axistream_packet_arbiter
//
// Bench for axistream_packet_arbiter (DATA_WIDTH=8, NUM_PACK=4, NUM_SRC=2).
// Sources are driven from per-source beat queues; every beat offered is also
// queued as the expected output of that source. A monitor checks per-source
// order, packet non-interleaving, output stability under back-pressure,
// grant exclusivity and round-robin fairness. Directed scenarios add exact
// expected sequences on top.
// ---------------------------------------------------------------------------
module tb_axistream_packet_arbiter;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int NS = 2;
    localparam int W  = DW * NP;
    localparam int TW = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS-1:0]     src_tvalid;
    logic [NS-1:0]     src_tready;
    logic [NS*W-1:0]   src_tdata;
    logic [NS-1:0]     src_tlast;
    logic              dest_tvalid;
    logic              dest_tready;
    logic [W-1:0]      dest_tdata;
    logic              dest_tlast;
    logic [TW-1:0]     dest_tid;
    logic              busy;

    axistream_packet_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_PACK  (NP),
        .NUM_SRC   (NS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_tvalid (src_tvalid),
        .src_tready (src_tready),
        .src_tdata  (src_tdata),
        .src_tlast  (src_tlast),
        .dest_tvalid(dest_tvalid),
        .dest_tready(dest_tready),
        .dest_tdata (dest_tdata),
        .dest_tlast (dest_tlast),
        .dest_tid   (dest_tid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Source beats still to be offered, and expected dest words per source.
    logic [W-1:0] txd  [NS][$];
    bit           txl  [NS][$];
    logic [W-1:0] expd [NS][$];
    bit           expl [NS][$];

    // Log of delivered dest words for the directed scenarios.
    logic [W-1:0] logd [$];
    int           logt [$];
    bit           logl [$];

    bit           midpkt   [NS];
    int           wait_cnt [NS];
    bit           out_inpkt;
    int           out_tid;
    bit           prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_last;
    logic [TW-1:0] prev_tid;
    logic [NS-1:0] acc_s;
    int           vprob = 100;
    int           rprob = 100;
    bit           verbose = 1'b1;
    bit           rec_en = 1'b0;
    bit           tr [$];

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic enqueue(input int s, input logic [W-1:0] d, input bit l);
        txd[s].push_back(d);
        txl[s].push_back(l);
        expd[s].push_back(d);
        expl[s].push_back(l);
    endtask

    task automatic enq_random(input int s);
        int len;
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
            enqueue(s, $urandom, (i == len - 1));
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < NS; s++) begin
            txd[s].delete();
            txl[s].delete();
            expd[s].delete();
            expl[s].delete();
            midpkt[s]   = 1'b0;
            wait_cnt[s] = 0;
        end
        out_inpkt  = 1'b0;
        out_tid    = 0;
        prev_stall = 1'b0;
        acc_s      = '0;
    endtask

    // Observe one cycle at the falling edge: the handshakes seen here are the
    // ones the next rising edge will complete.
    task automatic monitor();
        logic [NS-1:0] others;
        int            t;
        @(negedge clk);
        acc_s = src_tvalid & src_tready;
        check_value("rdy_onehot", 64'($countones(src_tready) > 1), 64'(0));
        check_value("rdy_when_idle", 64'(src_tready & {NS{~busy}}), 64'(0));
        for (int s = 0; s < NS; s++) begin
            if (midpkt[s]) begin
                others = ~(NS'(1) << s);
                check_value("rdy_other_in_pkt", 64'(src_tready & others), 64'(0));
            end
        end
        if (prev_stall) begin
            check_value("stall_valid", 64'(dest_tvalid), 64'(1));
            check_value("stall_data", 64'(dest_tdata), 64'(prev_data));
            check_value("stall_last", 64'(dest_tlast), 64'(prev_last));
            check_value("stall_tid", 64'(dest_tid), 64'(prev_tid));
        end
        // A source waiting on its first beat may see at most NS-1 other
        // packets begin before its own.
        for (int s = 0; s < NS; s++) begin
            if (acc_s[s] && !midpkt[s]) begin
                check_value("fair_wait", 64'(wait_cnt[s] > NS - 1), 64'(0));
                wait_cnt[s] = 0;
                for (int o = 0; o < NS; o++) begin
                    if (o != s && src_tvalid[o] && !midpkt[o]) wait_cnt[o]++;
                end
            end
        end
        if (dest_tvalid && dest_tready) begin
            t = int'(dest_tid);
            check_value("sb_avail", 64'(expd[t].size() != 0), 64'(1));
            if (expd[t].size() != 0) begin
                check_value("sb_data", 64'(dest_tdata), 64'(expd[t][0]));
                check_value("sb_last", 64'(dest_tlast), 64'(expl[t][0]));
                void'(expd[t].pop_front());
                void'(expl[t].pop_front());
            end
            if (out_inpkt) check_value("no_interleave", 64'(t), 64'(out_tid));
            out_inpkt = !dest_tlast;
            out_tid   = t;
            logd.push_back(dest_tdata);
            logt.push_back(t);
            logl.push_back(dest_tlast);
            if (verbose) $display("dest word tid=%0d data=%h last=%0d", t, dest_tdata, dest_tlast);
        end
        for (int s = 0; s < NS; s++) begin
            if (acc_s[s]) midpkt[s] = !src_tlast[s];
        end
        if (rec_en) tr.push_back(src_tready[1]);
        prev_stall = dest_tvalid && !dest_tready;
        prev_data  = dest_tdata;
        prev_last  = dest_tlast;
        prev_tid   = dest_tid;
    endtask

    // Update stimulus just after the rising edge. A raised valid is held
    // until its beat is taken.
    task automatic drive();
        @(posedge clk);
        #1;
        for (int s = 0; s < NS; s++) begin
            if (acc_s[s]) begin
                void'(txd[s].pop_front());
                void'(txl[s].pop_front());
            end
            if (txd[s].size() == 0) begin
                src_tvalid[s] = 1'b0;
            end else begin
                if (!(src_tvalid[s] && !acc_s[s])) begin
                    src_tvalid[s] = ($urandom_range(0, 99) < vprob);
                end
                src_tdata[s*W +: W] = txd[s][0];
                src_tlast[s]        = txl[s][0];
            end
        end
        dest_tready = ($urandom_range(0, 99) < rprob);
        acc_s = '0;
    endtask

    task automatic cycle();
        monitor();
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            cycle();
            n++;
            done = (txd[0].size() == 0) && (txd[1].size() == 0) && !dest_tvalid;
        end
        check_value("drain_done", 64'(done), 64'(1));
        for (int s = 0; s < NS; s++) begin
            check_value("sb_leftover", 64'(expd[s].size()), 64'(0));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_tvalid"}, 64'(dest_tvalid), 64'(0));
        check_value({tag, "_busy"}, 64'(busy), 64'(0));
        check_value({tag, "_tready"}, 64'(src_tready), 64'(0));
        check_value({tag, "_tdata"}, 64'(dest_tdata), 64'(0));
        check_value({tag, "_tlast"}, 64'(dest_tlast), 64'(0));
        check_value({tag, "_tid"}, 64'(dest_tid), 64'(0));
    endtask

    task automatic finish_reset();
        src_tvalid  = '0;
        src_tlast   = '0;
        src_tdata   = '0;
        dest_tready = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        logd.delete();
        logt.delete();
        logl.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          found;
        bit          rdy1_seen;
        int          k;
        logic [4:0]  pat;
        logic [W-1:0] exp3 [4];

        rst_n       = 1'b1;
        src_tvalid  = '0;
        src_tlast   = '0;
        src_tdata   = '0;
        dest_tready = 1'b0;
        clear_model();

        // Reset takes effect before any clock edge.
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst0");
        finish_reset();

        // Two single-word packets: source 0 first after reset.
        clear_log();
        vprob = 100;
        rprob = 100;
        enqueue(0, 32'hA0A1A2A3, 1'b1);
        enqueue(1, 32'hB0B1B2B3, 1'b1);
        drain(50);
        check_value("t1_count", 64'(logd.size()), 64'(2));
        if (logd.size() >= 2) begin
            check_value("t1_w0", 64'(logd[0]), 64'(32'hA0A1A2A3));
            check_value("t1_tid0", 64'(logt[0]), 64'(0));
            check_value("t1_w1", 64'(logd[1]), 64'(32'hB0B1B2B3));
            check_value("t1_tid1", 64'(logt[1]), 64'(1));
        end

        // Source 1 requests mid-packet of source 0 and must wait.
        clear_log();
        enqueue(0, 32'h11111111, 1'b0);
        enqueue(0, 32'h22222222, 1'b0);
        enqueue(0, 32'h33333333, 1'b1);
        n = 0;
        while (!midpkt[0] && n < 20) begin
            cycle();
            n++;
        end
        check_value("t2_started", 64'(midpkt[0]), 64'(1));
        enqueue(1, 32'h44444444, 1'b1);
        rdy1_seen = 1'b0;
        n = 0;
        while (txd[0].size() != 0 && n < 30) begin
            #1 rdy1_seen = rdy1_seen | src_tready[1];
            cycle();
            n++;
        end
        check_value("t2_rdy1_low", 64'(rdy1_seen), 64'(0));
        drain(50);
        exp3[0] = 32'h11111111;
        exp3[1] = 32'h22222222;
        exp3[2] = 32'h33333333;
        exp3[3] = 32'h44444444;
        check_value("t2_count", 64'(logd.size()), 64'(4));
        if (logd.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check_value("t2_data", 64'(logd[i]), 64'(exp3[i]));
                check_value("t2_tid", 64'(logt[i]), 64'(i == 3 ? 1 : 0));
            end
        end

        // Back-pressure: output word must hold for five stalled cycles.
        clear_log();
        rprob = 0;
        enqueue(0, 32'hCAFEF00D, 1'b0);
        enqueue(0, 32'h12345678, 1'b1);
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            cycle();
            n++;
            found = dest_tvalid && (dest_tdata == 32'hCAFEF00D);
        end
        check_value("t3_loaded", 64'(found), 64'(1));
        for (int i = 0; i < 5; i++) begin
            #1;
            check_value("t3_hold_data", 64'(dest_tdata), 64'(32'hCAFEF00D));
            check_value("t3_hold_valid", 64'(dest_tvalid), 64'(1));
            check_value("t3_src_rdy", 64'(src_tready), 64'(0));
            cycle();
        end
        rprob = 100;
        drain(50);
        check_value("t3_count", 64'(logd.size()), 64'(2));
        if (logd.size() >= 2) begin
            check_value("t3_w0", 64'(logd[0]), 64'(32'hCAFEF00D));
            check_value("t3_w1", 64'(logd[1]), 64'(32'h12345678));
        end

        // Reset mid-packet: source 0 served last, source 1 locked, then reset
        // must restore source 0 as highest priority.
        enqueue(0, 32'h0A0A0A0A, 1'b1);
        drain(50);
        for (int i = 0; i < 4; i++) enqueue(1, 32'h5000_0000 + 32'(i), (i == 3));
        n = 0;
        while (txd[1].size() > 2 && n < 30) begin
            cycle();
            n++;
        end
        check_value("t4_two_taken", 64'(txd[1].size()), 64'(2));
        rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        finish_reset();
        clear_log();
        enqueue(0, 32'hC0C0C0C0, 1'b1);
        enqueue(1, 32'hD0D0D0D0, 1'b1);
        drain(50);
        check_value("t4_count", 64'(logd.size()), 64'(2));
        if (logd.size() >= 2) begin
            check_value("t4_first_tid", 64'(logt[0]), 64'(0));
            check_value("t4_first_data", 64'(logd[0]), 64'(32'hC0C0C0C0));
            check_value("t4_second_tid", 64'(logt[1]), 64'(1));
        end

        // Back-to-back packets from one source: one dead ready cycle between.
        clear_log();
        tr.delete();
        rec_en = 1'b1;
        enqueue(1, 32'h61616161, 1'b0);
        enqueue(1, 32'h62626262, 1'b1);
        enqueue(1, 32'h63636363, 1'b0);
        enqueue(1, 32'h64646464, 1'b1);
        drain(50);
        rec_en = 1'b0;
        k = 0;
        while (k < tr.size() && !tr[k]) k++;
        pat = '0;
        for (int j = 0; j < 5; j++) begin
            pat = {pat[3:0], (k + j < tr.size()) ? tr[k + j] : 1'b0};
        end
        check_value("t5_ready_pattern", 64'(pat), 64'(5'b11011));
        check_value("t5_count", 64'(logd.size()), 64'(4));
        for (int i = 0; i < logt.size(); i++) begin
            check_value("t5_tid", 64'(logt[i]), 64'(1));
        end

        // Randomized traffic with random valid gaps and back-pressure.
        verbose = 1'b0;
        vprob = 60;
        rprob = 70;
        for (int c = 0; c < 10000; c++) begin
            for (int s = 0; s < NS; s++) begin
                if (txd[s].size() < 2) enq_random(s);
            end
            cycle();
        end
        rprob = 100;
        vprob = 100;
        drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
